g2_hist_acc: RTL and testbench

Multi-lane histogram accumulator for the g2 correlation path. It sits between the per-lane delay-difference units and the host readout. Each cycle it increments up to LANES independent bin counters, one RAM bank per lane. On request it streams the cross-lane sum of every bin over a valid/ready port and clears each bin as it is read. It generalises the single-mode histogram memory with:
- parametrised lanes, depth and widths;
- self-clearing after reset;
- hazard forwarding;
- an explicit dump request;
- an overflow flag.

---
 rtl/g2_pkg.sv | 27 ++
 rtl/g2_hist_acc_if.sv | 17 +
 rtl/g2_hist_bank.sv | 107 ++++++++++
 rtl/g2_hist_acc.sv | 193 +++++++++++++++++++
 tb/tb_g2_hist_acc.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/g2_pkg.sv
// g2_pkg: shared types and helpers for the g2 histogram accumulator.
//   - g2_state_e : controller states (init sweep, accumulate, drain, dump)
//   - clog2      : ceiling log2 for sizing pointers
//   - Def*       : default geometry used by the top-level parameters
package g2_pkg;

    localparam int unsigned DefLanes   = 32;
    localparam int unsigned DefBinBits = 10;
    localparam int unsigned DefCntBits = 18;

    typedef enum logic [1:0] {
        StInit,
        StAccum,
        StDrain,
        StDump
    } g2_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/g2_hist_acc_if.sv
// g2_hist_acc_if: readout stream of the g2 histogram accumulator.
//   g2Dat  : summed bin count (SUM_BITS)
//   g2V    : g2Dat valid
//   g2R    : consumer ready; a word transfers on g2V && g2R
//   g2Last : marks the word for the highest bin
// Modports: master (accumulator side), slave (consumer side).
interface g2_hist_acc_if #(
    parameter int unsigned SUM_BITS = 32
);
    logic [SUM_BITS-1:0] g2Dat;
    logic                g2V;
    logic                g2R;
    logic                g2Last;

    modport master (output g2Dat, output g2V, output g2Last, input g2R);
    modport slave  (input g2Dat, input g2V, input g2Last, output g2R);
endinterface

// File: rtl/g2_hist_bank.sv
// g2_hist_bank: one lane's histogram RAM with a read-modify-write increment pipeline.
//   S0 registers the hit and issues the read, S1 receives read data and computes
//   count+1, S2 writes it back. A clear port writes zero to clr_addr_i and reads the
//   same address (old data) for the dump path.
// Ports:
//   clk, RST          : clock, synchronous active-low reset
//   inc_v_i/inc_bin_i : accepted hit and its bin
//   clr_i/clr_addr_i  : write zero at clr_addr_i and read it onto rd_data_o next cycle
//   rd_data_o         : registered RAM read data
//   ovf_o             : pulses when an increment starts from all-ones
// Build option: G2_HIST_SAT_EN makes counters saturate instead of wrapping.
module g2_hist_bank #(
    parameter int unsigned BIN_BITS = 10,
    parameter int unsigned CNT_BITS = 18
) (
    input  logic                clk,
    input  logic                RST,
    input  logic                inc_v_i,
    input  logic [BIN_BITS-1:0] inc_bin_i,
    input  logic                clr_i,
    input  logic [BIN_BITS-1:0] clr_addr_i,
    output logic [CNT_BITS-1:0] rd_data_o,
    output logic                ovf_o
);
    logic [CNT_BITS-1:0] mem [2**BIN_BITS];
    logic [CNT_BITS-1:0] rdata_q;

    logic                s0_v_q, s0_v_d, s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic [BIN_BITS-1:0] s0_bin_q, s0_bin_d, s1_bin_q, s1_bin_d, s2_bin_q, s2_bin_d;
    logic                s1_fwd_v_q, s1_fwd_v_d;
    logic [CNT_BITS-1:0] s1_fwd_val_q, s1_fwd_val_d, s2_val_q, s2_val_d;
    logic [CNT_BITS-1:0] s1_base, s1_new;
    logic [BIN_BITS-1:0] raddr, waddr;
    logic                we;
    logic [CNT_BITS-1:0] wdata;

    always_comb begin
        s1_base = s1_fwd_v_q ? s1_fwd_val_q : rdata_q;
        s1_new  = s1_base + CNT_BITS'(1);
`ifdef G2_HIST_SAT_EN
        if (s1_base == '1) begin
            s1_new = s1_base;
        end
`endif
        ovf_o = s1_v_q && (s1_base == '1);

        s0_v_d   = inc_v_i;
        s0_bin_d = inc_bin_i;
        s1_v_d   = s0_v_q;
        s1_bin_d = s0_bin_q;
        s2_v_d   = s1_v_q;
        s2_bin_d = s1_bin_q;
        s2_val_d = s1_new;

        // The read issued from S0 this cycle cannot see the writes still pending in S1
        // and S2; capture the newest of them so S1 uses it instead of RAM data.
        s1_fwd_v_d   = 1'b0;
        s1_fwd_val_d = s2_val_q;
        if (s1_v_q && (s1_bin_q == s0_bin_q)) begin
            s1_fwd_v_d   = 1'b1;
            s1_fwd_val_d = s1_new;
        end else if (s2_v_q && (s2_bin_q == s0_bin_q)) begin
            s1_fwd_v_d   = 1'b1;
            s1_fwd_val_d = s2_val_q;
        end

        raddr = clr_i ? clr_addr_i : s0_bin_q;
        we    = s2_v_q | clr_i;
        waddr = s2_v_q ? s2_bin_q : clr_addr_i;
        wdata = s2_v_q ? s2_val_q : '0;
    end

    // Read-during-write to the same address returns the old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            s0_v_q       <= 1'b0;
            s1_v_q       <= 1'b0;
            s2_v_q       <= 1'b0;
            s0_bin_q     <= '0;
            s1_bin_q     <= '0;
            s2_bin_q     <= '0;
            s1_fwd_v_q   <= 1'b0;
            s1_fwd_val_q <= '0;
            s2_val_q     <= '0;
        end else begin
            s0_v_q       <= s0_v_d;
            s1_v_q       <= s1_v_d;
            s2_v_q       <= s2_v_d;
            s0_bin_q     <= s0_bin_d;
            s1_bin_q     <= s1_bin_d;
            s2_bin_q     <= s2_bin_d;
            s1_fwd_v_q   <= s1_fwd_v_d;
            s1_fwd_val_q <= s1_fwd_val_d;
            s2_val_q     <= s2_val_d;
        end
    end

    assign rd_data_o = rdata_q;

endmodule

// File: rtl/g2_hist_acc.sv
// g2_hist_acc: multi-lane histogram accumulator with clear-on-read dump.
//   After reset all bins are swept to zero, then each lane increments its own bank.
//   dump_req drains the increment pipeline and streams the cross-lane sum of every bin,
//   bin 0 first, clearing each bin as it is read.
// Ports:
//   clk, RST          : clock, synchronous active-low reset
//   hit_v, hit_bin    : per-lane hit valid and bin (lane i at [i*BIN_BITS +: BIN_BITS])
//   hit_r             : hits accepted (accumulate state only)
//   dump_req          : start readout, honoured only while accumulating
//   busy              : high whenever not accumulating
//   ovf_flag          : sticky, set when any counter increments from all-ones
//   g2_io             : readout stream (g2Dat/g2V/g2R/g2Last)
// Build option: G2_HIST_SAT_EN selects saturating instead of wrapping counters.
module g2_hist_acc
    import g2_pkg::*;
#(
    parameter int unsigned LANES      = DefLanes,
    parameter int unsigned BIN_BITS   = DefBinBits,
    parameter int unsigned CNT_BITS   = DefCntBits,
    parameter int unsigned SUM_BITS   = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      RST,
    input  logic [LANES-1:0]          hit_v,
    input  logic [LANES*BIN_BITS-1:0] hit_bin,
    output logic                      hit_r,
    input  logic                      dump_req,
    output logic                      busy,
    output logic                      ovf_flag,
    g2_hist_acc_if.master             g2_io
);
    localparam int unsigned PtrW = clog2(FIFO_DEPTH);
    localparam int unsigned OccW = PtrW + 2;
    localparam logic [BIN_BITS-1:0] LastBin = {BIN_BITS{1'b1}};

    g2_state_e           state_q, state_d;
    logic [BIN_BITS-1:0] ptr_q, ptr_d;
    logic [1:0]          drain_q, drain_d;
    logic                issued_all_q, issued_all_d;
    logic                rd_v_q, rd_v_d, rd_last_q, rd_last_d;
    logic                sum_v_q, sum_v_d, sum_last_q, sum_last_d;
    logic [SUM_BITS-1:0] sum_q, sum_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]       cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [SUM_BITS-1:0] fifo_dat_q [FIFO_DEPTH];
    logic                fifo_last_q [FIFO_DEPTH];

    logic                clr, issue, push, pop, g2_v, g2_last;
    logic [OccW-1:0]     occ;
    logic [CNT_BITS-1:0] rdata [LANES];
    logic [LANES-1:0]    ovf_vec;

    for (genvar i = 0; i < LANES; i++) begin : g_bank
        g2_hist_bank #(
            .BIN_BITS (BIN_BITS),
            .CNT_BITS (CNT_BITS)
        ) u_bank (
            .clk        (clk),
            .RST        (RST),
            .inc_v_i    (hit_v[i] & hit_r),
            .inc_bin_i  (hit_bin[i*BIN_BITS +: BIN_BITS]),
            .clr_i      (clr),
            .clr_addr_i (ptr_q),
            .rd_data_o  (rdata[i]),
            .ovf_o      (ovf_vec[i])
        );
    end

    always_comb begin
        sum_d = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            sum_d = sum_d + SUM_BITS'(rdata[i]);
        end
    end

    assign g2_v            = (cnt_q != '0);
    assign g2_last         = g2_v & fifo_last_q[rd_ptr_q];
    assign g2_io.g2V       = g2_v;
    assign g2_io.g2Last    = g2_last;
    assign g2_io.g2Dat     = fifo_dat_q[rd_ptr_q];
    assign ovf_flag        = ovf_q;
    assign push            = sum_v_q;
    assign pop             = g2_v & g2_io.g2R;
    // Words already committed to the FIFO path: stored plus still in the read/sum stages.
    assign occ = OccW'(cnt_q) + OccW'(rd_v_q) + OccW'(sum_v_q);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        drain_d      = drain_q;
        issued_all_d = issued_all_q;
        clr          = 1'b0;
        issue        = 1'b0;
        hit_r        = 1'b0;
        busy         = 1'b1;
        unique case (state_q)
            StInit: begin
                clr   = 1'b1;
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LastBin) begin
                    state_d = StAccum;
                end
            end
            StAccum: begin
                hit_r = 1'b1;
                busy  = 1'b0;
                if (dump_req) begin
                    state_d = StDrain;
                    drain_d = '0;
                end
            end
            StDrain: begin
                // Three cycles let the last accepted hit reach its S2 write.
                drain_d = drain_q + 1'b1;
                if (drain_q == 2'd2) begin
                    state_d = StDump;
                end
            end
            StDump: begin
                if (!issued_all_q && (occ < OccW'(FIFO_DEPTH))) begin
                    issue = 1'b1;
                    clr   = 1'b1;
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == LastBin) begin
                        issued_all_d = 1'b1;
                    end
                end
                if (pop && g2_last) begin
                    state_d      = StAccum;
                    issued_all_d = 1'b0;
                end
            end
            default: state_d = StInit;
        endcase

        rd_v_d     = issue;
        rd_last_d  = issue && (ptr_q == LastBin);
        sum_v_d    = rd_v_q;
        sum_last_d = rd_last_q;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d      = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        ovf_d = ovf_q | (|ovf_vec);
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            state_q      <= StInit;
            ptr_q        <= '0;
            drain_q      <= '0;
            issued_all_q <= 1'b0;
            rd_v_q       <= 1'b0;
            rd_last_q    <= 1'b0;
            sum_v_q      <= 1'b0;
            sum_last_q   <= 1'b0;
            sum_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_dat_q[i]  <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            drain_q      <= drain_d;
            issued_all_q <= issued_all_d;
            rd_v_q       <= rd_v_d;
            rd_last_q    <= rd_last_d;
            sum_v_q      <= sum_v_d;
            sum_last_q   <= sum_last_d;
            sum_q        <= sum_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            if (push) begin
                fifo_dat_q[wr_ptr_q]  <= sum_q;
                fifo_last_q[wr_ptr_q] <= sum_last_q;
            end
        end
    end

endmodule

// File: tb/tb_g2_hist_acc.sv
// Directed bench for g2_hist_acc: 32 lanes, 1024 bins, 4-bit lane counters.
module tb_g2_hist_acc;
    localparam int unsigned LANES      = 32;
    localparam int unsigned BIN_BITS   = 10;
    localparam int unsigned CNT_BITS   = 4;
    localparam int unsigned SUM_BITS   = 32;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int          NBINS      = 1 << BIN_BITS;

    logic                      clk = 1'b0;
    logic                      RST = 1'b0;
    logic [LANES-1:0]          hit_v = '0;
    logic [LANES*BIN_BITS-1:0] hit_bin = '0;
    logic                      hit_r;
    logic                      dump_req = 1'b0;
    logic                      busy;
    logic                      ovf_flag;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_word [NBINS];

    g2_hist_acc_if #(.SUM_BITS(SUM_BITS)) g2_bus ();

    g2_hist_acc #(
        .LANES      (LANES),
        .BIN_BITS   (BIN_BITS),
        .CNT_BITS   (CNT_BITS),
        .SUM_BITS   (SUM_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .RST      (RST),
        .hit_v    (hit_v),
        .hit_bin  (hit_bin),
        .hit_r    (hit_r),
        .dump_req (dump_req),
        .busy     (busy),
        .ovf_flag (ovf_flag),
        .g2_io    (g2_bus)
    );

    always #5 clk = ~clk;

    task automatic clear_exp();
        for (int i = 0; i < NBINS; i++) exp_word[i] = 0;
    endtask

    task automatic set_hit(input int lane, input int bin);
        hit_v[lane] = 1'b1;
        hit_bin[lane*BIN_BITS +: BIN_BITS] = BIN_BITS'(bin);
    endtask

    task automatic clear_hits();
        hit_v   = '0;
        hit_bin = '0;
    endtask

    // Called at a negedge with RST just released; counts negedges until hit_r rises.
    task automatic wait_ready(input string tag);
        int cyc = 0;
        while (hit_r !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc != NBINS) begin
            n_fail++;
            $display("FAIL %s init length: got %0d cycles, want %0d", tag, cyc, NBINS);
        end
    endtask

    // Pulses dump_req (with whatever hits the caller left set) and collects nwords words.
    task automatic collect_dump(input int nwords, input bit bp, input string tag);
        int                  idx = 0;
        int                  cyc = 0;
        logic                pst = 1'b0;
        logic                pl  = 1'b0;
        logic [SUM_BITS-1:0] pd  = '0;
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        clear_hits();
        n_cmp++;
        if (hit_r !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s drain: hit_r=%b busy=%b, want 0 1", tag, hit_r, busy);
        end
        while (idx < nwords && cyc < 6000) begin
            logic                v, l, r, want_l;
            logic [SUM_BITS-1:0] d;
            v = g2_bus.g2V;
            d = g2_bus.g2Dat;
            l = g2_bus.g2Last;
            if (pst) begin
                n_cmp++;
                if (v !== 1'b1 || d !== pd || l !== pl) begin
                    n_fail++;
                    $display("FAIL %s hold at word %0d: v=%b dat=%0d last=%b, want 1 %0d %b",
                             tag, idx, v, d, l, pd, pl);
                end
            end
            r = bp ? (cyc % 3 == 2) : 1'b1;
            g2_bus.g2R = r;
            if (v === 1'b1 && r) begin
                want_l = (idx == NBINS - 1);
                n_cmp++;
                if (d !== SUM_BITS'(exp_word[idx]) || l !== want_l) begin
                    n_fail++;
                    $display("FAIL %s word %0d: got %0d last=%b, want %0d last=%b",
                             tag, idx, d, l, exp_word[idx], want_l);
                end
                idx++;
            end
            pst = (v === 1'b1) && !r;
            pd  = d;
            pl  = l;
            cyc++;
            @(negedge clk);
        end
        g2_bus.g2R = 1'b0;
        n_cmp++;
        if (idx != nwords) begin
            n_fail++;
            $display("FAIL %s word count: got %0d, want %0d", tag, idx, nwords);
        end
    endtask

    task automatic check_idle(input string tag);
        n_cmp++;
        if (busy !== 1'b0 || g2_bus.g2V !== 1'b0 || hit_r !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle: busy=%b g2V=%b hit_r=%b, want 0 0 1",
                     tag, busy, g2_bus.g2V, hit_r);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        clear_hits();
        dump_req   = 1'b0;
        g2_bus.g2R = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (hit_r !== 1'b0 || busy !== 1'b1 || g2_bus.g2V !== 1'b0 || g2_bus.g2Dat !== '0 ||
            g2_bus.g2Last !== 1'b0 || ovf_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL reset values: hit_r=%b busy=%b g2V=%b dat=%0d last=%b ovf=%b",
                     hit_r, busy, g2_bus.g2V, g2_bus.g2Dat, g2_bus.g2Last, ovf_flag);
        end
        RST = 1'b1;
        wait_ready("reset");
    endtask

    task automatic test_empty_dump();
        clear_exp();
        collect_dump(NBINS, 1'b0, "empty");
        check_idle("empty");
    endtask

    task automatic test_forwarding();
        clear_exp();
        exp_word[5] = 4;
        exp_word[7] = 2;
        set_hit(0, 5);
        set_hit(1, 7);
        @(negedge clk);
        clear_hits();
        set_hit(0, 5);
        set_hit(31, 5);
        @(negedge clk);
        clear_hits();
        // Last pair lands in the dump_req cycle and must still be counted.
        set_hit(0, 5);
        set_hit(1, 7);
        collect_dump(NBINS, 1'b0, "fwd");
        check_idle("fwd");
    endtask

    task automatic test_clear_on_read_backpressure();
        clear_exp();
        exp_word[NBINS-1] = 320;
        for (int c = 0; c < 10; c++) begin
            for (int ln = 0; ln < int'(LANES); ln++) set_hit(ln, NBINS - 1);
            @(negedge clk);
        end
        clear_hits();
        collect_dump(NBINS, 1'b1, "bp");
        check_idle("bp");
        clear_exp();
        collect_dump(NBINS, 1'b0, "cleared");
        check_idle("cleared");
    endtask

    task automatic test_overflow();
        n_cmp++;
        if (ovf_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf before: got %b, want 0", ovf_flag);
        end
        clear_exp();
`ifdef G2_HIST_SAT_EN
        exp_word[2] = 15;
`else
        exp_word[2] = 4;
`endif
        for (int c = 0; c < 20; c++) begin
            set_hit(0, 2);
            @(negedge clk);
        end
        clear_hits();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (ovf_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf after hits: got %b, want 1", ovf_flag);
        end
        collect_dump(NBINS, 1'b0, "ovf");
        n_cmp++;
        if (ovf_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf sticky: got %b, want 1", ovf_flag);
        end
    endtask

    task automatic test_reset_mid_dump();
        clear_exp();
        exp_word[100] = 1;
        exp_word[600] = 1;
        set_hit(3, 100);
        set_hit(4, 600);
        @(negedge clk);
        clear_hits();
        g2_bus.g2R = 1'b1;
        collect_dump(501, 1'b0, "pre_rst");
        g2_bus.g2R = 1'b1;
        RST = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (g2_bus.g2V !== 1'b0 || ovf_flag !== 1'b0 || hit_r !== 1'b0 || busy !== 1'b1 ||
            g2_bus.g2Dat !== '0) begin
            n_fail++;
            $display("FAIL mid-dump reset: g2V=%b ovf=%b hit_r=%b busy=%b dat=%0d",
                     g2_bus.g2V, ovf_flag, hit_r, busy, g2_bus.g2Dat);
        end
        g2_bus.g2R = 1'b0;
        RST = 1'b1;
        wait_ready("rerun");
        clear_exp();
        collect_dump(NBINS, 1'b0, "post_rst");
        check_idle("post_rst");
        n_cmp++;
        if (ovf_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf after reset: got %b, want 0", ovf_flag);
        end
    endtask

    initial begin
        g2_bus.g2R = 1'b0;
        test_reset();
        test_empty_dump();
        test_forwarding();
        test_clear_on_read_backpressure();
        test_overflow();
        test_reset_mid_dump();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
